// File: rtl/branch_target_predictor.sv
// Next-PC predictor for the IF stage: a direct-mapped branch target buffer
// with a 2-bit saturating counter per entry, trained by ID (jumps) and EX
// (conditional branches) resolution results.
// Optional build macro BP_STATS_EN adds branch/misprediction counters.
module branch_target_predictor #(
    parameter int WORD_SIZE        = 16,
    parameter int INDEX_BITS       = 8,
    parameter int BRANCH_PREDICTOR = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] fetch_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_taken,
    input  logic                 update_en,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_is_jump,
    input  logic                 bp_clear
`ifdef BP_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] num_pred_branch,
    output logic [WORD_SIZE-1:0] num_pred_miss
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    logic                 f_taken;
    logic [WORD_SIZE-1:0] f_target;
`ifdef BP_STATS_EN
    logic [WORD_SIZE-1:0] u_pred_pc;
`endif

    // Fall-through is pc+1 with natural modulo-2**WORD_SIZE wrap.
    assign pred_taken = f_taken;
    assign pred_pc    = f_taken ? f_target : fetch_pc + WORD_SIZE'(1);

    generate
        if (BRANCH_PREDICTOR != 0) begin : g_btb
            logic                 valid_q  [ENTRIES];
            logic [1:0]           ctr_q    [ENTRIES];
            logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
            logic [WORD_SIZE-1:0] target_q [ENTRIES];

            logic [INDEX_BITS-1:0] f_idx;
            logic [INDEX_BITS-1:0] u_idx;
            logic [TAG_BITS-1:0]   f_tag;
            logic [TAG_BITS-1:0]   u_tag;
            logic                  f_hit;
            logic                  u_hit;
            logic                  wr_en;
            logic [1:0]            wr_ctr_d;
            logic [WORD_SIZE-1:0]  wr_target_d;

            assign f_idx = fetch_pc[INDEX_BITS-1:0];
            assign f_tag = fetch_pc[WORD_SIZE-1:INDEX_BITS];
            assign u_idx = update_pc[INDEX_BITS-1:0];
            assign u_tag = update_pc[WORD_SIZE-1:INDEX_BITS];

            assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
            assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

            // Zero-latency lookup on pre-edge table state (no update bypass).
            assign f_taken  = f_hit && ctr_q[f_idx][1];
            assign f_target = target_q[f_idx];

`ifdef BP_STATS_EN
            assign u_pred_pc = (u_hit && ctr_q[u_idx][1]) ? target_q[u_idx]
                                                          : update_pc + WORD_SIZE'(1);
`endif

            // Decide whether and how the resolved instruction rewrites its entry.
            always_comb begin
                wr_en       = 1'b0;
                wr_ctr_d    = ctr_q[u_idx];
                wr_target_d = target_q[u_idx];
                if (update_en) begin
                    if (update_is_jump) begin
                        wr_en       = 1'b1;
                        wr_ctr_d    = 2'b11;
                        wr_target_d = update_target;
                    end else if (u_hit) begin
                        wr_en = 1'b1;
                        if (update_taken) begin
                            wr_ctr_d    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'b01;
                            wr_target_d = update_target;
                        end else begin
                            wr_ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'b01;
                        end
                    end else if (update_taken) begin
                        wr_en       = 1'b1;
                        wr_ctr_d    = 2'b10;
                        wr_target_d = update_target;
                    end
                end
            end

            // Table state: async reset, synchronous clear beats training writes.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < ENTRIES; i++) begin
                        valid_q[i]  <= 1'b0;
                        ctr_q[i]    <= 2'b01;
                        tag_q[i]    <= '0;
                        target_q[i] <= '0;
                    end
                end else if (bp_clear) begin
                    for (int i = 0; i < ENTRIES; i++) begin
                        valid_q[i] <= 1'b0;
                        ctr_q[i]   <= 2'b01;
                    end
                end else if (wr_en) begin
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    ctr_q[u_idx]    <= wr_ctr_d;
                    target_q[u_idx] <= wr_target_d;
                end
            end
        end else begin : g_static
            // Always-not-taken: no table, training inputs are ignored.
            assign f_taken  = 1'b0;
            assign f_target = '0;
`ifdef BP_STATS_EN
            assign u_pred_pc = update_pc + WORD_SIZE'(1);
`endif
        end
    endgenerate

`ifdef BP_STATS_EN
    logic [WORD_SIZE-1:0] resolved_pc;
    logic [WORD_SIZE-1:0] branch_cnt_q;
    logic [WORD_SIZE-1:0] miss_cnt_q;

    assign resolved_pc     = update_taken ? update_target : update_pc + WORD_SIZE'(1);
    assign num_pred_branch = branch_cnt_q;
    assign num_pred_miss   = miss_cnt_q;

    // Resolution statistics; wrap naturally and survive bp_clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (update_en) begin
            branch_cnt_q <= branch_cnt_q + WORD_SIZE'(1);
            if (u_pred_pc != resolved_pc) begin
                miss_cnt_q <= miss_cnt_q + WORD_SIZE'(1);
            end
        end
    end
`endif

endmodule
